instr_assembly_register: RTL

// - Parametrised successor to the two-half instruction register: builds an IR_W-bit instruction from BEATS bus beats of BUS_W bits.
// - Streaming valid/ready input with an internal beat counter; legacy direct slice write kept; IR output qualified by IRValid/Consume.
// - Sits between the memory data bus and the control unit/decoder of the basic computer.

---
 rtl/ir_pkg.sv | 10 +
 rtl/ir_beat_counter.sv | 26 ++
 rtl/instr_assembly_register.sv | 87 ++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the instruction assembly register and its beat counter.
package ir_pkg;
  localparam int IR_BUS_W_DEF = 8;
  localparam int IR_BEATS_DEF = 2;

  // Width of a beat/slice index; never zero so BEATS==1 still has a port.
  function automatic int sel_width(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction
endpackage

// File: rtl/ir_beat_counter.sv
// Modulo-BEATS beat index counter; o_wrap flags that the next increment wraps to 0.
module ir_beat_counter
  import ir_pkg::*;
#(
  parameter  int BEATS = IR_BEATS_DEF,
  localparam int SEL_W = sel_width(BEATS)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [SEL_W-1:0] o_cnt,
  output logic             o_wrap
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(BEATS - 1);

  logic [SEL_W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_wrap = (r_cnt == LAST);

  always_ff @(posedge Clock) begin
    if (Reset || i_clr)  r_cnt <= '0;
    else if (i_inc)      r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/instr_assembly_register.sv
// Assembles an IR_W-bit instruction from BEATS little-endian bus beats.
// IR_PREFETCH_EN: non-final beats may fill the shadow while IROut is still held.
module instr_assembly_register
  import ir_pkg::*;
#(
  parameter  int BUS_W = IR_BUS_W_DEF,
  parameter  int BEATS = IR_BEATS_DEF,
  localparam int IR_W  = BUS_W * BEATS,
  localparam int SEL_W = sel_width(BEATS)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [BUS_W-1:0] I,
  input  logic             InValid,
  output logic             InReady,
  input  logic             Write,
  input  logic [SEL_W-1:0] Sel,
  input  logic             Flush,
  input  logic             Consume,
  output logic [IR_W-1:0]  IROut,
  output logic             IRValid,
  output logic [SEL_W-1:0] BeatCnt
);
  logic [IR_W-1:0] r_ir;
  logic [IR_W-1:0] r_shadow;
  logic            r_vld;

  logic            w_final;
  logic            w_ir_free;
  logic            w_slot_ok;
  logic            w_take;
  logic [IR_W-1:0] w_asm;
  logic [IR_W-1:0] w_wr_ir;

  ir_beat_counter #(.BEATS(BEATS)) u_cnt (
    .Clock  (Clock),
    .Reset  (Reset),
    .i_clr  (Flush),
    .i_inc  (w_take),
    .o_cnt  (BeatCnt),
    .o_wrap (w_final)
  );

  assign w_ir_free = !r_vld || Consume;

`ifdef IR_PREFETCH_EN
  assign w_slot_ok = w_final ? w_ir_free : 1'b1;
`else
  assign w_slot_ok = w_ir_free;
`endif

  assign InReady = !Reset && !Write && !Flush && w_slot_ok;
  assign w_take  = InValid && InReady;

  // Shadow with the incoming beat dropped into its slot; for the final beat
  // this is the complete instruction.
  always_comb begin
    w_asm = r_shadow;
    w_asm[int'(BeatCnt)*BUS_W +: BUS_W] = I;
    w_wr_ir = r_ir;
    if (int'(Sel) < BEATS) w_wr_ir[int'(Sel)*BUS_W +: BUS_W] = I;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ir     <= '0;
      r_shadow <= '0;
      r_vld    <= 1'b0;
    end else if (Flush) begin
      r_shadow <= '0;
      r_vld    <= 1'b0;
    end else begin
      if (Write) r_ir <= w_wr_ir;
      if (w_take && w_final) begin
        r_ir     <= w_asm;
        r_shadow <= '0;
        r_vld    <= 1'b1;
      end else begin
        if (w_take) r_shadow <= w_asm;
        if (Consume && r_vld) r_vld <= 1'b0;
      end
    end
  end

  assign IROut   = r_ir;
  assign IRValid = r_vld;
endmodule
